// File: rtl/cu_control_box.sv
// Compute-unit control box: sequences config load, token-gated passes and run completion.
// Optional 8-bit RUN watchdog is compiled in when CU_CTRL_TIMEOUT_EN is defined.
module cu_control_box #(
    parameter int unsigned ITER_W   = 8,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_start,
    input  logic [ITER_W-1:0] io_iters,
    input  logic              io_tokenIn,
    input  logic              io_cuDone,
    output logic              io_config_enable,
    output logic              io_cuEnable,
    output logic              io_tokenOut,
    output logic              io_busy,
    output logic              io_done,
    output logic [ITER_W-1:0] io_passCount,
    output logic              io_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StWaitTok,
        StRun,
        StDone
    } state_e;

    localparam logic [CREDIT_W-1:0] CreditMax = '1;

    state_e              r_state;
    state_e              w_state_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [ITER_W-1:0]   r_iters;
    logic [ITER_W-1:0]   r_pass_count;
    logic [ITER_W-1:0]   w_pass_inc;
    logic                r_token_out;
    logic                r_timeout;
    logic                w_accept;
    logic                w_pass_done;
    logic                w_credit_inc;
    logic                w_credit_dec;
    logic                w_wdog_expire;

    assign w_accept     = (r_state == StIdle) && io_start;
    assign w_pass_done  = (r_state == StRun) && io_cuDone;
    assign w_pass_inc   = r_pass_count + ITER_W'(1);
    assign w_credit_dec = (r_state == StWaitTok) && (r_credit != '0);
    // At saturation a token is still usable when it offsets a same-cycle consume.
    assign w_credit_inc = io_tokenIn && ((r_credit != CreditMax) || w_credit_dec);

`ifdef CU_CTRL_TIMEOUT_EN
    logic [7:0] r_wdog;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state != StRun) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    // Fires on the 255th consecutive RUN cycle without a pass completion.
    assign w_wdog_expire = (r_state == StRun) && !io_cuDone && (r_wdog == 8'd254);
`else
    assign w_wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (io_start) begin
                    w_state_next = StConfig;
                end
            end
            StConfig: begin
                w_state_next = (r_iters == '0) ? StDone : StWaitTok;
            end
            StWaitTok: begin
                if (r_credit != '0) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (io_cuDone) begin
                    w_state_next = (w_pass_inc == r_iters) ? StDone : StWaitTok;
                end else if (w_wdog_expire) begin
                    w_state_next = StIdle;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit     <= '0;
            r_iters      <= '0;
            r_pass_count <= '0;
            r_token_out  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_token_out <= w_pass_done;
            if (w_accept) begin
                r_iters      <= io_iters;
                r_pass_count <= '0;
                r_timeout    <= 1'b0;
            end else begin
                if (w_pass_done) begin
                    r_pass_count <= w_pass_inc;
                end
                if (w_wdog_expire) begin
                    r_timeout <= 1'b1;
                end
            end
            if (w_credit_inc && !w_credit_dec) begin
                r_credit <= r_credit + CREDIT_W'(1);
            end else if (w_credit_dec && !w_credit_inc) begin
                r_credit <= r_credit - CREDIT_W'(1);
            end
        end
    end

    // Outputs are forced low while reset is held, independent of the registered state.
    always_comb begin
        io_config_enable = 1'b0;
        io_cuEnable      = 1'b0;
        io_tokenOut      = 1'b0;
        io_busy          = 1'b0;
        io_done          = 1'b0;
        io_passCount     = '0;
        io_timeout       = 1'b0;
        if (!reset) begin
            io_config_enable = (r_state == StConfig);
            io_cuEnable      = (r_state == StRun);
            io_tokenOut      = r_token_out;
            io_busy          = (r_state != StIdle);
            io_done          = (r_state == StDone);
            io_passCount     = r_pass_count;
            io_timeout       = r_timeout;
        end
    end

endmodule

// File: tb/tb_cu_control_box.sv
// Directed self-checking bench for cu_control_box (default ITER_W=8, CREDIT_W=4).
module tb_cu_control_box;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_start;
    logic [7:0] io_iters;
    logic       io_tokenIn;
    logic       io_cuDone;
    logic       io_config_enable;
    logic       io_cuEnable;
    logic       io_tokenOut;
    logic       io_busy;
    logic       io_done;
    logic [7:0] io_passCount;
    logic       io_timeout;

    int checks = 0;
    int errors = 0;

    // Per-run observations collected by run().
    int n_cfg, n_win, n_tok, n_done, cyc_done, last_win, k_end;
    int win_start [4];

    cu_control_box dut (
        .clk              (clk),
        .reset            (reset),
        .io_start         (io_start),
        .io_iters         (io_iters),
        .io_tokenIn       (io_tokenIn),
        .io_cuDone        (io_cuDone),
        .io_config_enable (io_config_enable),
        .io_cuEnable      (io_cuEnable),
        .io_tokenOut      (io_tokenOut),
        .io_busy          (io_busy),
        .io_done          (io_done),
        .io_passCount     (io_passCount),
        .io_timeout       (io_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            io_tokenIn = 1'b1;
            tick();
        end
        io_tokenIn = 1'b0;
    endtask

    // Start a run in the current cycle (k=0) and follow it until IDLE or max_cyc.
    // cuDone is raised on the done_lat-th consecutive RUN cycle (0 = never).
    task automatic run(input int iters, input int done_lat, input int tok_a, input int tok_b,
                       input int st_at, input int max_cyc);
        int   run_cnt;
        logic prev_en;
        n_cfg = 0; n_win = 0; n_tok = 0; n_done = 0; cyc_done = -1; last_win = -1; k_end = 0;
        for (int i = 0; i < 4; i++) win_start[i] = -1;
        run_cnt  = 0;
        prev_en  = 1'b0;
        io_start = 1'b1;
        io_iters = 8'(iters);
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            io_start = (k == st_at);
            if (k == st_at) io_iters = 8'hff;
            io_tokenIn = (k == tok_a) || (k == tok_b);
            if (io_config_enable) n_cfg++;
            if (io_cuEnable && !prev_en) begin
                if (n_win < 4) win_start[n_win] = k;
                last_win = k;
                n_win++;
            end
            if (io_tokenOut) n_tok++;
            if (io_done) begin
                n_done++;
                cyc_done = k;
            end
            run_cnt   = io_cuEnable ? run_cnt + 1 : 0;
            io_cuDone = io_cuEnable && (run_cnt == done_lat);
            prev_en   = io_cuEnable;
            k_end     = k;
            if (!io_busy) break;
        end
        io_start   = 1'b0;
        io_tokenIn = 1'b0;
        io_cuDone  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; io_start = 1'b0; io_iters = '0; io_tokenIn = 1'b0; io_cuDone = 1'b0;
        tick();
        tick();
        checks++; if ({io_config_enable, io_cuEnable, io_tokenOut, io_busy, io_done, io_timeout} !== 6'b0)
            begin errors++; $display("FAIL rst_flags got %b want 000000", {io_config_enable,
                io_cuEnable, io_tokenOut, io_busy, io_done, io_timeout}); end
        checks++; if (io_passCount !== 8'd0)
            begin errors++; $display("FAIL rst_pass got %0d want 0", io_passCount); end
        reset = 1'b0;
        tick();
        checks++; if (io_busy !== 1'b0)
            begin errors++; $display("FAIL rst_idle_busy got %b want 0", io_busy); end
    endtask

    // Credit must be zero here: the single pass waits for a token given at k=8.
    task automatic check_credit_empty(input string tag);
        run(1, 1, 8, -1, -1, 40);
        checks++; if (win_start[0] !== 10)
            begin errors++; $display("FAIL %s_empty_win got %0d want 10", tag, win_start[0]); end
        checks++; if (cyc_done !== 11)
            begin errors++; $display("FAIL %s_empty_done got %0d want 11", tag, cyc_done); end
    endtask

    task automatic test_basic;
        preload(2);
        run(2, 4, -1, -1, 5, 40);
        checks++; if (n_cfg !== 1) begin errors++; $display("FAIL basic_cfg got %0d want 1", n_cfg); end
        checks++; if (n_win !== 2) begin errors++; $display("FAIL basic_win got %0d want 2", n_win); end
        checks++; if (win_start[0] !== 3)
            begin errors++; $display("FAIL basic_lat got %0d want 3", win_start[0]); end
        checks++; if (win_start[1] !== 8)
            begin errors++; $display("FAIL basic_win2 got %0d want 8", win_start[1]); end
        checks++; if (n_tok !== 2) begin errors++; $display("FAIL basic_tok got %0d want 2", n_tok); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", n_done); end
        checks++; if (cyc_done !== 12)
            begin errors++; $display("FAIL basic_done_cyc got %0d want 12", cyc_done); end
        checks++; if (io_passCount !== 8'd2)
            begin errors++; $display("FAIL basic_pass got %0d want 2", io_passCount); end
        tick();
        checks++; if (io_passCount !== 8'd2)
            begin errors++; $display("FAIL basic_pass_hold got %0d want 2", io_passCount); end
        check_credit_empty("basic");
    endtask

    task automatic test_zero_iters;
        run(0, 1, -1, -1, -1, 10);
        checks++; if (n_cfg !== 1) begin errors++; $display("FAIL zero_cfg got %0d want 1", n_cfg); end
        checks++; if (n_win !== 0) begin errors++; $display("FAIL zero_win got %0d want 0", n_win); end
        checks++; if (n_tok !== 0) begin errors++; $display("FAIL zero_tok got %0d want 0", n_tok); end
        checks++; if (cyc_done !== 2)
            begin errors++; $display("FAIL zero_done_cyc got %0d want 2", cyc_done); end
        checks++; if (io_passCount !== 8'd0)
            begin errors++; $display("FAIL zero_pass got %0d want 0", io_passCount); end
    endtask

    task automatic test_stall;
        preload(1);
        run(3, 4, 16, 30, -1, 80);
        checks++; if (win_start[1] !== 18)
            begin errors++; $display("FAIL stall_resume1 got %0d want 18", win_start[1]); end
        checks++; if (win_start[2] !== 32)
            begin errors++; $display("FAIL stall_resume2 got %0d want 32", win_start[2]); end
        checks++; if (n_tok !== 3) begin errors++; $display("FAIL stall_tok got %0d want 3", n_tok); end
        checks++; if (cyc_done !== 36)
            begin errors++; $display("FAIL stall_done_cyc got %0d want 36", cyc_done); end
        checks++; if (io_passCount !== 8'd3)
            begin errors++; $display("FAIL stall_pass got %0d want 3", io_passCount); end
    endtask

    task automatic test_saturation;
        preload(20);
        run(16, 1, 40, -1, -1, 80);
        checks++; if (n_win !== 16) begin errors++; $display("FAIL sat_win got %0d want 16", n_win); end
        checks++; if (last_win !== 42)
            begin errors++; $display("FAIL sat_last_win got %0d want 42", last_win); end
        checks++; if (cyc_done !== 43)
            begin errors++; $display("FAIL sat_done_cyc got %0d want 43", cyc_done); end
        checks++; if (io_passCount !== 8'd16)
            begin errors++; $display("FAIL sat_pass got %0d want 16", io_passCount); end
    endtask

    task automatic test_simultaneous;
        preload(1);
        run(2, 2, 2, -1, -1, 40);
        checks++; if (win_start[1] !== 6)
            begin errors++; $display("FAIL simul_win2 got %0d want 6", win_start[1]); end
        checks++; if (cyc_done !== 8)
            begin errors++; $display("FAIL simul_done_cyc got %0d want 8", cyc_done); end
        check_credit_empty("simul");
    endtask

    task automatic test_reset_midrun;
        preload(3);
        io_start = 1'b1; io_iters = 8'd2;
        tick();                                   // k1 CONFIG
        io_start = 1'b0;
        tick();                                   // k2 WAIT_TOK
        tick();                                   // k3 RUN
        io_cuDone = 1'b1;
        tick();                                   // k4 WAIT_TOK
        io_cuDone = 1'b0;
        tick();                                   // k5 RUN
        checks++; if (io_cuEnable !== 1'b1 || io_passCount !== 8'd1)
            begin errors++; $display("FAIL rstrun_pre got en=%b pass=%0d want en=1 pass=1",
                io_cuEnable, io_passCount); end
        io_cuDone = 1'b1; reset = 1'b1;
        #1;
        checks++; if ({io_cuEnable, io_tokenOut, io_busy, io_done} !== 4'b0 || io_passCount !== 8'd0)
            begin errors++; $display("FAIL rstrun_held got flags=%b pass=%0d want 0000/0",
                {io_cuEnable, io_tokenOut, io_busy, io_done}, io_passCount); end
        tick();
        io_cuDone = 1'b0; reset = 1'b0;
        #1;
        checks++; if ({io_cuEnable, io_tokenOut, io_busy, io_done, io_config_enable} !== 5'b0)
            begin errors++; $display("FAIL rstrun_after got %b want 00000",
                {io_cuEnable, io_tokenOut, io_busy, io_done, io_config_enable}); end
        checks++; if (io_passCount !== 8'd0)
            begin errors++; $display("FAIL rstrun_pass got %0d want 0", io_passCount); end
        tick();
        checks++; if (io_tokenOut !== 1'b0)
            begin errors++; $display("FAIL rstrun_tok got %b want 0", io_tokenOut); end
        check_credit_empty("rstrun");
    endtask

    task automatic test_watchdog;
        preload(1);
        run(1, 0, -1, -1, -1, 300);
        checks++; if (n_done !== 0) begin errors++; $display("FAIL wd_done got %0d want 0", n_done); end
`ifdef CU_CTRL_TIMEOUT_EN
        checks++; if (k_end !== 258) begin errors++; $display("FAIL wd_exit got %0d want 258", k_end); end
        checks++; if (io_timeout !== 1'b1 || io_busy !== 1'b0)
            begin errors++; $display("FAIL wd_flag got to=%b busy=%b want to=1 busy=0",
                io_timeout, io_busy); end
        tick();
        tick();
        checks++; if (io_timeout !== 1'b1)
            begin errors++; $display("FAIL wd_sticky got %b want 1", io_timeout); end
        run(0, 1, -1, -1, -1, 10);
        checks++; if (io_timeout !== 1'b0)
            begin errors++; $display("FAIL wd_clear got %b want 0", io_timeout); end
`else
        checks++; if (k_end !== 300 || io_busy !== 1'b1 || io_cuEnable !== 1'b1)
            begin errors++; $display("FAIL wd_run got k=%0d busy=%b en=%b want 300/1/1",
                k_end, io_busy, io_cuEnable); end
        checks++; if (io_timeout !== 1'b0)
            begin errors++; $display("FAIL wd_flag got %b want 0", io_timeout); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (io_busy !== 1'b0)
            begin errors++; $display("FAIL wd_recover got %b want 0", io_busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_iters();
        test_stall();
        test_saturation();
        test_simultaneous();
        test_reset_midrun();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
